// File: rtl/mlp_pkg.sv
// mlp_pkg: shared FP32 field positions, constants, the argmax state
// encoding and a NaN predicate used by the MLP datapath blocks.
package mlp_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_W   = 23;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } argmax_state_e;

  function automatic logic is_nan(input logic [31:0] v);
    return (v[EXP_MSB:EXP_LSB] == 8'hFF) && (v[MANT_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/fp32_gt.sv
// fp32_gt: combinational strict greater-than on two IEEE-754 FP32 values.
//   a, b    : FP32 operands
//   a_gt_b  : 1 when a > b; +0 and -0 compare equal; NaNs are treated
//             as ordinary sign/magnitude bit patterns.
module fp32_gt
  import mlp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        a_gt_b
);

  logic        sa, sb;
  logic [30:0] ma, mb;

  assign sa = a[SIGN_BIT];
  assign sb = b[SIGN_BIT];
  assign ma = a[EXP_MSB:0];
  assign mb = b[EXP_MSB:0];

  always_comb begin
    a_gt_b = 1'b0;
    if ((ma == '0) && (mb == '0)) begin
      // both zeros, whatever their signs
      a_gt_b = 1'b0;
    end else if (sa != sb) begin
      a_gt_b = !sa;
    end else if (!sa) begin
      a_gt_b = (ma > mb);
    end else begin
      // both negative: smaller magnitude is the larger value
      a_gt_b = (ma < mb);
    end
  end

endmodule

// File: rtl/mlp_argmax.sv
// mlp_argmax: scans the final layer's N_CLASSES FP32 scores one per cycle
// after a rising edge of layer_end and reports the index/value of the max.
//   CLK          : clock, rising edge
//   reset        : synchronous, active-high
//   scores       : flat FP32 vector, score i at bits [32*i +: 32]
//   layer_end    : high = scores valid and held stable by upstream
//   class_idx    : index of the maximum score (lowest index on ties)
//   max_value    : FP32 value of the maximum score
//   result_valid : class_idx/max_value valid
//   busy         : scan in progress
//   nan_seen     : a NaN was skipped (only with NAN_CHECK_EN, else 0)
// Build option: `define NAN_CHECK_EN to skip NaN entries during the scan.
//
// state | meaning
// IDLE  | no result; waiting for layer_end rising edge
// SCAN  | comparing scores[ptr] against the running max
// DONE  | result held until next start or reset
module mlp_argmax
  import mlp_pkg::*;
#(
  parameter int N_CLASSES = 10,
  parameter int IDX_W     = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [32*N_CLASSES-1:0] scores,
  input  logic                   layer_end,
  output logic [IDX_W-1:0]       class_idx,
  output logic [31:0]            max_value,
  output logic                   result_valid,
  output logic                   busy,
  output logic                   nan_seen
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CLASSES - 1);

  argmax_state_e    state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      max_q, max_d;
  logic             valid_q, valid_d;
  logic             nan_q, nan_d;
  logic             le_q;
  logic             start;
  logic [31:0]      cand;
  logic             cand_gt;
  logic [31:0]      sc [N_CLASSES];

  for (genvar i = 0; i < N_CLASSES; i++) begin : g_unpack
    assign sc[i] = scores[32*i +: 32];
  end

  assign start = layer_end && !le_q;
  assign cand  = sc[ptr_q];

  fp32_gt u_gt (
    .a      (cand),
    .b      (max_q),
    .a_gt_b (cand_gt)
  );

`ifdef NAN_CHECK_EN
  // have_q: a non-NaN entry has been taken as the running max
  logic have_q, have_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    max_d   = max_q;
    valid_d = valid_q;
    nan_d   = nan_q;
`ifdef NAN_CHECK_EN
    have_d  = have_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          max_d   = sc[0];
          idx_d   = '0;
          ptr_d   = IDX_W'(1);
          valid_d = 1'b0;
          nan_d   = 1'b0;
          state_d = SCAN;
`ifdef NAN_CHECK_EN
          have_d = !is_nan(sc[0]);
          if (is_nan(sc[0])) begin
            nan_d = 1'b1;
            max_d = FP_QNAN;
          end
`endif
          if (N_CLASSES == 1) begin
            state_d = DONE;
            valid_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (!layer_end) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else begin
`ifdef NAN_CHECK_EN
          if (is_nan(cand)) begin
            nan_d = 1'b1;
          end else if (!have_q || cand_gt) begin
            max_d  = cand;
            idx_d  = ptr_q;
            have_d = 1'b1;
          end
`else
          if (cand_gt) begin
            max_d = cand;
            idx_d = ptr_q;
          end
`endif
          if (ptr_q == LAST) begin
            state_d = DONE;
            valid_d = 1'b1;
          end else begin
            ptr_d = ptr_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      max_q   <= FP_ZERO;
      valid_q <= 1'b0;
      nan_q   <= 1'b0;
      le_q    <= 1'b0;
`ifdef NAN_CHECK_EN
      have_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      max_q   <= max_d;
      valid_q <= valid_d;
      nan_q   <= nan_d;
      le_q    <= layer_end;
`ifdef NAN_CHECK_EN
      have_q  <= have_d;
`endif
    end
  end

  assign class_idx    = idx_q;
  assign max_value    = max_q;
  assign result_valid = valid_q;
  assign busy         = (state_q == SCAN);
`ifdef NAN_CHECK_EN
  assign nan_seen     = nan_q;
`else
  assign nan_seen     = 1'b0;
`endif

endmodule

// File: tb/tb_mlp_argmax.sv
module tb_mlp_argmax;
  import mlp_pkg::*;

  localparam int N = 10;
`ifdef NAN_CHECK_EN
  localparam bit NAN_MODE = 1'b1;
`else
  localparam bit NAN_MODE = 1'b0;
`endif

  typedef logic [31:0] vec_t [N];

  logic          clk = 1'b0;
  logic          reset;
  logic [32*N-1:0] scores;
  logic          layer_end;
  logic [3:0]    class_idx;
  logic [31:0]   max_value;
  logic          result_valid, busy, nan_seen;

  logic [31:0]   scores1;
  logic [0:0]    class_idx1;
  logic [31:0]   max_value1;
  logic          result_valid1, busy1, nan_seen1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mlp_argmax #(.N_CLASSES(N)) dut (
    .CLK(clk), .reset(reset), .scores(scores), .layer_end(layer_end),
    .class_idx(class_idx), .max_value(max_value), .result_valid(result_valid),
    .busy(busy), .nan_seen(nan_seen)
  );

  mlp_argmax #(.N_CLASSES(1)) dut1 (
    .CLK(clk), .reset(reset), .scores(scores1), .layer_end(layer_end),
    .class_idx(class_idx1), .max_value(max_value1), .result_valid(result_valid1),
    .busy(busy1), .nan_seen(nan_seen1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // total order of FP32 values as signed integers; +0 and -0 both map to 0
  function automatic longint fkey(input logic [31:0] v);
    longint m;
    m = longint'(v[30:0]);
    return v[31] ? -m : m;
  endfunction

  function automatic void model(input vec_t v, output int idx, output logic [31:0] val,
                                output logic nan);
    bit found;
    found = 0; idx = 0; val = FP_QNAN; nan = 0;
    for (int i = 0; i < N; i++) begin
      if (NAN_MODE && is_nan(v[i])) begin
        nan = 1'b1;
      end else if (!found || fkey(v[i]) > fkey(val)) begin
        found = 1; idx = i; val = v[i];
      end
    end
  endfunction

  task automatic load(input vec_t v, input logic [31:0] s1);
    for (int i = 0; i < N; i++) scores[32*i +: 32] = v[i];
    scores1 = s1;
  endtask

  task automatic run_scan(input string tag, input vec_t v, input int exp_idx,
                          input logic [31:0] s1);
    int e_idx;
    logic [31:0] e_val;
    logic e_nan;
    int lat;
    model(v, e_idx, e_val, e_nan);
    @(negedge clk); layer_end = 1'b0;
    @(negedge clk); load(v, s1); layer_end = 1'b1;
    @(negedge clk);
    check({tag, ".busy_start"}, busy, 1);
    check({tag, ".rv_start"}, result_valid, 0);
    check({tag, ".n1_rv"}, result_valid1, 1);
    check({tag, ".n1_idx"}, class_idx1, 0);
    check({tag, ".n1_val"}, max_value1, (NAN_MODE && is_nan(s1)) ? FP_QNAN : s1);
    check({tag, ".n1_busy"}, busy1, 0);
    check({tag, ".n1_nan"}, nan_seen1, NAN_MODE && is_nan(s1));
    lat = 1;
    while (!result_valid && lat < 20) begin
      @(negedge clk); lat++;
    end
    check({tag, ".latency"}, lat, N);
    check({tag, ".idx"}, class_idx, e_idx);
    check({tag, ".val"}, max_value, e_val);
    check({tag, ".busy_end"}, busy, 0);
    check({tag, ".nan"}, nan_seen, e_nan);
    if (exp_idx >= 0) check({tag, ".dir_idx"}, class_idx, exp_idx);
  endtask

  function automatic logic [31:0] rnd_score();
    logic [31:0] pool [4];
    pool[0] = 32'h0000_0000; pool[1] = 32'h8000_0000;
    pool[2] = 32'h3F80_0000; pool[3] = 32'hBF80_0000;
    if ($urandom_range(0, 3) == 0) return pool[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  initial begin
    vec_t v;
    logic bad;
    logic [3:0]  h_idx;
    logic [31:0] h_val;

    reset = 1'b1; layer_end = 1'b0;
    for (int i = 0; i < N; i++) v[i] = 32'h3F80_0000;
    load(v, 32'h3F80_0000);
    repeat (3) @(negedge clk);
    check("rst.idx", class_idx, 0);
    check("rst.val", max_value, 0);
    check("rst.rv", result_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.nan", nan_seen, 0);
    check("rst.n1_rv", result_valid1, 0);
    reset = 1'b0;

    v = '{32'h3DCC_CCCD, 32'h3F00_0000, 32'h4040_0000, 32'h3F80_0000, 32'h3E80_0000,
          32'h3F00_0000, 32'h3F80_0000, 32'h3E80_0000, 32'h3DCC_CCCD, 32'h3F80_0000};
    run_scan("pos", v, 2, 32'h4040_0000);

    v = '{32'hC080_0000, 32'hBF80_0000, 32'hC000_0000, 32'hC040_0000, 32'hC040_0000,
          32'hC080_0000, 32'hC040_0000, 32'hC000_0000, 32'hC040_0000, 32'hC080_0000};
    run_scan("neg", v, 1, 32'hBF80_0000);

    for (int i = 0; i < N; i++) v[i] = 32'h3F80_0000;
    v[3] = 32'h4000_0000; v[7] = 32'h4000_0000;
    run_scan("tie", v, 3, 32'h8000_0000);

    for (int i = 0; i < N; i++) v[i] = 32'hC000_0000;
    v[0] = 32'h8000_0000; v[1] = 32'h0000_0000;
    run_scan("zero", v, 0, 32'h0000_0000);

    // layer_end stays high: no rescan, outputs frozen
    bad = 1'b0; h_idx = class_idx; h_val = max_value;
    repeat (50) begin
      @(negedge clk);
      if (!result_valid || busy || class_idx !== h_idx || max_value !== h_val) bad = 1'b1;
    end
    check("hold.stable", bad, 0);

    for (int i = 0; i < N; i++) v[i] = 32'h3F00_0000;
    v[9] = 32'h40A0_0000;
    run_scan("rescan", v, 9, 32'hC000_0000);

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < N; i++) v[i] = rnd_score();
      run_scan($sformatf("rnd%0d", r), v, -1, rnd_score());
    end

    v[0] = 32'h7FC0_0000; v[4] = 32'h40A0_0000;
    for (int i = 1; i < N; i++) if (i != 4) v[i] = 32'h3F80_0000;
    run_scan("nan1", v, NAN_MODE ? 4 : 0, 32'h7FC0_0000);

    v = '{32'h7FC0_0000, 32'h7F80_0001, 32'hFFC0_0000, 32'h7FC0_0000, 32'hFF80_0010,
          32'h7FC0_0000, 32'h7FFF_FFFF, 32'h7FC0_0000, 32'hFFC0_0001, 32'h7FC0_0000};
    run_scan("nanall", v, NAN_MODE ? 0 : 6, 32'hFFC0_0000);

    // abort: layer_end falls at scan cycle 4
    @(negedge clk); layer_end = 1'b0;
    @(negedge clk); layer_end = 1'b1;
    repeat (4) @(negedge clk);
    check("abort.busy_pre", busy, 1);
    layer_end = 1'b0;
    @(negedge clk);
    check("abort.rv", result_valid, 0);
    check("abort.busy", busy, 0);
    repeat (12) @(negedge clk);
    check("abort.idle_rv", result_valid, 0);
    check("abort.idle_busy", busy, 0);

    // reset mid-scan
    layer_end = 1'b1;
    repeat (3) @(negedge clk);
    check("rstmid.busy_pre", busy, 1);
    reset = 1'b1; layer_end = 1'b0;
    @(negedge clk);
    check("rstmid.idx", class_idx, 0);
    check("rstmid.val", max_value, 0);
    check("rstmid.rv", result_valid, 0);
    check("rstmid.busy", busy, 0);
    check("rstmid.nan", nan_seen, 0);
    check("rstmid.n1_rv", result_valid1, 0);
    reset = 1'b0;

    for (int i = 0; i < N; i++) v[i] = 32'hBF80_0000;
    v[5] = 32'h3F80_0000;
    run_scan("post_rst", v, 5, 32'h3F80_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
